// File: rtl/hdlc_rx_frame_buffer_if.sv
// hdlc_rx_frame_buffer_if: Rx controller and host signals of the HDLC receive frame buffer
interface hdlc_rx_frame_buffer_if #(
    parameter int DATA_W = 8,
    parameter int SIZE_W = 8
);
    logic              Rx_ValidFrame;
    logic [DATA_W-1:0] Rx_Data;
    logic              Rx_WrBuff;
    logic              Rx_EoF;
    logic              Rx_AbortSignal;
    logic              Rx_FrameError;
    logic              Rx_FCSen;
    logic              Rx_FCSerr;
    logic              Rx_Drop;
    logic              Rx_RdBuff;
    logic              Rx_Ready;
    logic [DATA_W-1:0] Rx_DataBuffOut;
    logic [SIZE_W-1:0] Rx_FrameSize;
    logic              Rx_Overflow;
    modport master (
        output Rx_ValidFrame, Rx_Data, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_FrameError,
               Rx_FCSen, Rx_FCSerr, Rx_Drop, Rx_RdBuff,
        input  Rx_Ready, Rx_DataBuffOut, Rx_FrameSize, Rx_Overflow
    );
    modport slave (
        input  Rx_ValidFrame, Rx_Data, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_FrameError,
               Rx_FCSen, Rx_FCSerr, Rx_Drop, Rx_RdBuff,
        output Rx_Ready, Rx_DataBuffOut, Rx_FrameSize, Rx_Overflow
    );
endinterface

// File: rtl/hdlc_rx_frame_buffer.sv
// hdlc_rx_frame_buffer: collects one received HDLC frame and hands complete good frames to the host
module hdlc_rx_frame_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    parameter int SIZE_W = $clog2(DEPTH + 1)
) (
    input logic Clk,
    input logic Rst,
    hdlc_rx_frame_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, FILL, READY} state_t;
    state_t            state_q, state_d;
    logic [SIZE_W-1:0] count_q, count_d, size_q, size_d, cnt_w, fsize;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d, waddr;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ready_q, ready_d, ovf_q, ovf_d;
    logic              we, full, bad, last;
    logic [DATA_W-1:0] mem [DEPTH];
    always_comb begin
        full     = count_q == SIZE_W'(DEPTH);
        we       = bus.Rx_WrBuff && ((state_q == IDLE && bus.Rx_ValidFrame) || (state_q == FILL && !full));
        waddr    = state_q == IDLE ? '0 : count_q[AW-1:0];
        // byte count including a write landing in the same cycle as end-of-frame
        cnt_w    = state_q == IDLE ? SIZE_W'(1) : count_q + SIZE_W'(we);
        fsize    = !bus.Rx_FCSen ? cnt_w : (cnt_w > SIZE_W'(2) ? cnt_w - SIZE_W'(2) : '0);
        bad      = bus.Rx_AbortSignal || bus.Rx_FrameError || (bus.Rx_FCSen && bus.Rx_FCSerr);
        last     = SIZE_W'(rd_ptr_q) == size_q - SIZE_W'(1);
        state_d  = state_q;
        count_d  = count_q;
        size_d   = size_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        ready_d  = ready_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: if (we) begin
                state_d = FILL;
                count_d = cnt_w;
                ovf_d   = 1'b0;
            end
            FILL: begin
                count_d = cnt_w;
                if (bus.Rx_WrBuff && full) ovf_d = 1'b1;
                if (bus.Rx_EoF) begin
                    count_d = '0;
                    state_d = IDLE;
                    if (!bad && fsize != '0) begin
                        state_d = READY;
                        size_d  = fsize;
                        ready_d = 1'b1;
                    end
                end else if (!bus.Rx_ValidFrame) begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            READY: begin
                if (bus.Rx_WrBuff) ovf_d = 1'b1;
                if (bus.Rx_Drop) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    rd_ptr_d = '0;
                end else if (bus.Rx_RdBuff) begin
                    dout_d   = mem[rd_ptr_q];
                    rd_ptr_d = last ? '0 : rd_ptr_q + 1'b1;
                    ready_d  = !last;
                    state_d  = last ? IDLE : READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            size_q   <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            ready_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            size_q   <= size_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
        end
    end
    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= bus.Rx_Data;
    end
    assign bus.Rx_Ready       = ready_q;
    assign bus.Rx_DataBuffOut = dout_q;
    assign bus.Rx_FrameSize   = size_q;
    assign bus.Rx_Overflow    = ovf_q;
endmodule

// File: tb/tb_hdlc_rx_frame_buffer.sv
// tb_hdlc_rx_frame_buffer: directed and randomized frames checked against a queue-based frame model
module tb_hdlc_rx_frame_buffer;
    localparam int DEPTH  = 16;
    localparam int SIZE_W = 5;
    typedef struct {
        logic              rdy;
        logic              ovf;
        logic [SIZE_W-1:0] size;
        logic              chk_size;
        logic [7:0]        dout;
        logic              rd;
    } exp_t;
    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;
    hdlc_rx_frame_buffer_if #(.DATA_W(8), .SIZE_W(SIZE_W)) bus ();
    hdlc_rx_frame_buffer #(.DATA_W(8), .DEPTH(DEPTH), .SIZE_W(SIZE_W)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] m_frame[$];
    logic [7:0] m_buf[$];
    logic [7:0] m_out;
    bit m_col, m_rdy, m_ovf;
    int m_size;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endfunction

    // frame-level model: bytes collected into a queue, handed over as a payload queue on a good end
    task automatic model_step(output exp_t e);
        int n, sz;
        e.rd = 1'b0;
        if (Rst) begin
            m_frame.delete(); m_buf.delete();
            m_col = 0; m_rdy = 0; m_ovf = 0; m_size = 0; m_out = '0;
        end else if (m_rdy) begin
            if (bus.Rx_WrBuff) m_ovf = 1;
            if (bus.Rx_Drop) begin
                m_rdy = 0;
                m_buf.delete();
            end else if (bus.Rx_RdBuff) begin
                m_out = m_buf.pop_front();
                e.rd = 1'b1;
                if (m_buf.size() == 0) m_rdy = 0;
            end
        end else if (m_col) begin
            if (bus.Rx_WrBuff) begin
                if (m_frame.size() < DEPTH) m_frame.push_back(bus.Rx_Data);
                else m_ovf = 1;
            end
            if (bus.Rx_EoF) begin
                n = m_frame.size();
                sz = bus.Rx_FCSen ? (n > 2 ? n - 2 : 0) : n;
                m_col = 0;
                if (!(bus.Rx_AbortSignal || bus.Rx_FrameError || (bus.Rx_FCSen && bus.Rx_FCSerr)) && sz > 0) begin
                    m_rdy = 1;
                    m_size = sz;
                    m_buf.delete();
                    for (int i = 0; i < sz; i++) m_buf.push_back(m_frame[i]);
                end
            end else if (!bus.Rx_ValidFrame) begin
                m_col = 0;
            end
        end else if (bus.Rx_WrBuff && bus.Rx_ValidFrame) begin
            m_frame.delete();
            m_frame.push_back(bus.Rx_Data);
            m_col = 1;
            m_ovf = 0;
        end
        e.rdy = m_rdy;
        e.ovf = m_ovf;
        e.size = SIZE_W'(m_size);
        e.chk_size = m_rdy || Rst;
        e.dout = m_out;
    endtask

    task automatic tick();
        exp_t e;
        model_step(e);
        sb.push_back(e);
        @(posedge Clk);
        #1;
        Rst = 0; bus.Rx_WrBuff = 0; bus.Rx_EoF = 0; bus.Rx_AbortSignal = 0;
        bus.Rx_FrameError = 0; bus.Rx_FCSerr = 0; bus.Rx_Drop = 0; bus.Rx_RdBuff = 0;
    endtask

    // err: 0 good, 1 abort, 2 frame error, 3 FCS error, 4 ended by loss of ValidFrame
    task automatic frame(input int n, input bit fcs, input int err, input int base, input bit gaps);
        bus.Rx_FCSen = fcs;
        bus.Rx_ValidFrame = 1;
        for (int i = 0; i < n; i++) begin
            bus.Rx_WrBuff = 1;
            bus.Rx_Data = base < 0 ? 8'($urandom) : 8'(base + i);
            if (i == n - 1 && err != 4) begin
                bus.Rx_EoF = 1;
                bus.Rx_AbortSignal = err == 1;
                bus.Rx_FrameError = err == 2;
                bus.Rx_FCSerr = err == 3;
            end
            tick();
            if (gaps) repeat ($urandom_range(0, 2)) tick();
        end
        bus.Rx_ValidFrame = 0;
        tick();
    endtask

    task automatic read(input int k, input bit gaps);
        for (int i = 0; i < k; i++) begin
            bus.Rx_RdBuff = 1;
            tick();
            if (gaps) repeat ($urandom_range(0, 1)) tick();
        end
    endtask

    always @(posedge Clk) begin
        #2;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("ready", 32'(bus.Rx_Ready), 32'(mon_e.rdy));
            check("overflow", 32'(bus.Rx_Overflow), 32'(mon_e.ovf));
            check(mon_e.rd ? "read_data" : "dout_hold", 32'(bus.Rx_DataBuffOut), 32'(mon_e.dout));
            if (mon_e.chk_size) check("frame_size", 32'(bus.Rx_FrameSize), 32'(mon_e.size));
        end
    end

    initial begin
        int n, err;
        Rst = 1; bus.Rx_ValidFrame = 0; bus.Rx_Data = '0; bus.Rx_WrBuff = 0; bus.Rx_EoF = 0;
        bus.Rx_AbortSignal = 0; bus.Rx_FrameError = 0; bus.Rx_FCSen = 0; bus.Rx_FCSerr = 0;
        bus.Rx_Drop = 0; bus.Rx_RdBuff = 0;
        tick();
        Rst = 1;
        tick();
        tick();
        frame(10, 1, 0, 'h01, 0); read(8, 0); tick();
        frame(6, 1, 3, 'h20, 0); frame(4, 0, 0, 'h30, 0); read(4, 0);
        frame(20, 0, 0, 'h40, 0); read(16, 0); frame(3, 0, 0, 'h60, 0); read(3, 0);
        frame(5, 0, 0, 'h70, 0); read(2, 0);
        bus.Rx_Drop = 1; bus.Rx_RdBuff = 1; tick(); tick(); read(1, 0);
        frame(4, 0, 1, 'h80, 0);
        frame(4, 0, 0, 'h90, 0); read(1, 0); Rst = 1; tick(); read(2, 0);
        frame(6, 0, 0, 'hA0, 0); bus.Rx_WrBuff = 1; bus.Rx_Data = 8'hEE; tick(); read(6, 0);
        frame(2, 1, 0, 'hB0, 0); read(1, 0);
        repeat (250) begin
            n = $urandom_range(1, DEPTH + 4);
            err = $urandom_range(0, 9);
            frame(n, 1'($urandom), err > 4 ? 0 : err, -1, 1);
            if ($urandom_range(0, 3) == 0) begin
                bus.Rx_WrBuff = 1; bus.Rx_Data = 8'($urandom); tick();
            end
            if ($urandom_range(0, 9) == 0) begin
                Rst = 1; tick();
            end
            if ($urandom_range(0, 4) == 0) begin
                read(int'($urandom_range(0, m_buf.size())), 1);
                bus.Rx_Drop = 1; bus.Rx_RdBuff = 1'($urandom); tick();
            end
            read(m_buf.size() + int'($urandom_range(0, 1)), 1);
        end
        repeat (2) tick();
        @(posedge Clk);
        #5;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
